// File: rtl/egg_pkg.sv
// rtl/egg_pkg.sv - shared widths, debounce state encoding and counter sizing for the egg counter
package egg_pkg;

  localparam int MAX_EGGS_DEF = 4;
  localparam int NUM_W        = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } deb_state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizes one raw key and emits a single press pulse per debounced press
module key_debounce
  import egg_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int            CW       = cnt_w(DEBOUNCE_MS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          meta;
  logic          sync;
  deb_state_t    state;
  deb_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          armed;
  logic          armed_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= armed_nxt;
    end
  end

  // After reset IDLE stays disarmed until a full debounce window of lows,
  // so a key held through reset never produces a pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    armed_nxt = armed;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (!armed) begin
          if (sync) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_LAST) begin
            armed_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (sync) begin
          state_nxt = CONFIRM_PRESS;
          cnt_nxt   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_nxt = CONFIRM_RELEASE;
          cnt_nxt   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          armed_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/egg_count_ctrl.sv
// rtl/egg_count_ctrl.sv - debounced add/take/clear keys driving a saturating egg count with error flag
module egg_count_ctrl
  import egg_pkg::*;
#(
  parameter int MAX_EGGS    = MAX_EGGS_DEF,
  parameter int DEBOUNCE_MS = 20,
  parameter int ERR_MS      = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_add,
  input  logic             btn_take,
  input  logic             btn_clr,
  output logic [NUM_W-1:0] num,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [NUM_W-1:0] MAX_NUM  = NUM_W'(MAX_EGGS);
  localparam int               TW       = cnt_w(ERR_MS);
  localparam logic [TW-1:0]    ERR_LOAD = TW'(ERR_MS - 1);

  logic             add_p;
  logic             take_p;
  logic             clr_p;
  logic [NUM_W-1:0] num_nxt;
  logic             err_trig;
  logic [TW-1:0]    err_tmr;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_add (
    .clk(clk), .rst(rst), .raw(btn_add), .press(add_p)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_take (
    .clk(clk), .rst(rst), .raw(btn_take), .press(take_p)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clr (
    .clk(clk), .rst(rst), .raw(btn_clr), .press(clr_p)
  );

  // Clear wins outright; simultaneous add and take cancel without error.
  always_comb begin
    num_nxt  = num;
    err_trig = 1'b0;
    if (clr_p) begin
      num_nxt = '0;
    end else if (add_p && take_p) begin
      num_nxt = num;
    end else if (add_p) begin
      if (num < MAX_NUM) num_nxt = num + 1'b1;
      else               err_trig = 1'b1;
    end else if (take_p) begin
      if (num != '0) num_nxt = num - 1'b1;
      else           err_trig = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num     <= '0;
      err     <= 1'b0;
      err_tmr <= '0;
    end else begin
      num <= num_nxt;
      if (err_trig) begin
        err     <= 1'b1;
        err_tmr <= ERR_LOAD;
      end else if (err) begin
        if (err_tmr == '0) err <= 1'b0;
        else               err_tmr <= err_tmr - 1'b1;
      end
    end
  end

  assign full  = (num == MAX_NUM);
  assign empty = (num == '0);

endmodule

// File: tb/tb_egg_count_ctrl.sv
// tb/tb_egg_count_ctrl.sv - directed checks of debounce latency, saturation, error timing and reset
module tb_egg_count_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_add;
  logic       btn_take;
  logic       btn_clr;
  logic [2:0] num;
  logic       full;
  logic       empty;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  egg_count_ctrl #(.MAX_EGGS(4), .DEBOUNCE_MS(4), .ERR_MS(8)) dut (
    .clk(clk), .rst(rst), .btn_add(btn_add), .btn_take(btn_take), .btn_clr(btn_clr),
    .num(num), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raw key high long enough for one pulse (effect visible on return), then released and settled.
  task automatic press(input int k);
    if (k == 0) btn_add = 1'b1; else if (k == 1) btn_take = 1'b1; else btn_clr = 1'b1;
    tick(7);
    btn_add = 1'b0; btn_take = 1'b0; btn_clr = 1'b0;
    tick(10);
  endtask

  initial begin
    logic [4:0] bounce;
    bounce = 5'b01101;
    rst = 1'b1; btn_add = 1'b0; btn_take = 1'b0; btn_clr = 1'b0;
    tick(3);
    chk("rst_num", num, 0);
    chk("rst_err", err, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst = 1'b0;
    tick(8);

    // clean press: pulse in cycle 5, num visible after edge 6
    btn_add = 1'b1;
    tick(6);
    chk("t1_before", num, 0);
    tick(1);
    chk("t1_num", num, 1);
    chk("t1_err", err, 0);
    tick(3);
    chk("t1_hold", num, 1);
    btn_add = 1'b0;
    tick(10);

    // bouncing press 1,0,1,1,0 then stable
    for (int i = 0; i < 5; i++) begin
      btn_add = bounce[i];
      tick(1);
    end
    btn_add = 1'b1;
    tick(6);
    chk("t2_wait", num, 1);
    tick(1);
    chk("t2_num", num, 2);
    tick(50);
    chk("t2_held", num, 2);
    btn_add = 1'b0;
    tick(10);

    // saturation and error retrigger
    press(2);
    chk("t3_clr", num, 0);
    for (int i = 1; i <= 4; i++) begin
      press(0);
      chk("t3_num", num, i);
      chk("t3_full", full, (i == 4) ? 1 : 0);
    end
    btn_add = 1'b1;          // illegal add pulse in cycle 5
    tick(1);
    btn_clr = 1'b1;          // clear pulse in cycle 6
    tick(4);
    btn_take = 1'b1;         // take-at-empty pulse in cycle 10
    tick(2);
    chk("t3_sat_num", num, 4);
    chk("t3_err_set", err, 1);
    tick(1);
    chk("t3_clr_num", num, 0);
    chk("t3_err_kept", err, 1);
    tick(4);
    chk("t3_retrig", err, 1);
    tick(3);
    chk("t3_extend", err, 1);
    tick(4);
    chk("t3_err_last", err, 1);
    tick(1);
    chk("t3_err_drop", err, 0);
    btn_add = 1'b0; btn_take = 1'b0; btn_clr = 1'b0;
    tick(12);

    // take at empty
    btn_take = 1'b1;
    tick(7);
    chk("t4_num", num, 0);
    chk("t4_empty", empty, 1);
    chk("t4_err_on", err, 1);
    tick(7);
    chk("t4_err_end", err, 1);
    tick(1);
    chk("t4_err_off", err, 0);
    btn_take = 1'b0;
    tick(10);

    // simultaneous add+take, then clr+add
    press(0);
    press(0);
    chk("t5_num2", num, 2);
    btn_add = 1'b1; btn_take = 1'b1;
    tick(7);
    chk("t5_addtake", num, 2);
    chk("t5_addtake_err", err, 0);
    btn_add = 1'b0; btn_take = 1'b0;
    tick(10);
    press(0);
    chk("t5_num3", num, 3);
    btn_add = 1'b1; btn_clr = 1'b1;
    tick(7);
    chk("t5_clradd", num, 0);
    chk("t5_clradd_err", err, 0);
    btn_add = 1'b0; btn_clr = 1'b0;
    tick(10);

    // reset with num=3, err=1, clr mid-confirm, add/take held through reset
    for (int i = 0; i < 4; i++) press(0);
    chk("t6_full", full, 1);
    btn_add = 1'b1;
    tick(1);
    btn_take = 1'b1;
    tick(4);
    btn_clr = 1'b1;
    tick(3);
    chk("t6_pre_num", num, 3);
    chk("t6_pre_err", err, 1);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_num", num, 0);
    chk("t6_rst_err", err, 0);
    rst = 1'b0;
    tick(15);
    chk("t6_held_num", num, 0);
    chk("t6_held_err", err, 0);
    btn_add = 1'b0; btn_take = 1'b0; btn_clr = 1'b0;
    tick(8);
    btn_add = 1'b1;
    tick(7);
    chk("t6_repress", num, 1);
    chk("t6_repress_err", err, 0);
    btn_add = 1'b0;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
